// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential reverse double-dabble BCD to binary converter
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    output logic [OUT_W-1:0]      y,
    output logic                  ovf,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    // Number of shifts needed to drain every BCD digit into the binary field.
    localparam int SHIFTS = $clog2(10 ** DIGITS);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int W_W    = BCD_W + SHIFTS;
    localparam int CNT_W  = $clog2(SHIFTS + 1);
    localparam int BW     = (SHIFTS > OUT_W) ? SHIFTS : OUT_W;
    localparam logic [BW-1:0] Y_MAX = BW'({OUT_W{1'b1}});

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [W_W-1:0]     w_shift;
    logic               digit_bad;
    logic [BW-1:0]      b_ext;
    logic               sat;

    // One reverse double-dabble step: shift right, then correct every BCD digit >= 8.
    always_comb begin
        w_shift = w_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_shift[SHIFTS+4*i +: 4] >= 4'd8) begin
                w_shift[SHIFTS+4*i +: 4] = w_shift[SHIFTS+4*i +: 4] - 4'd3;
            end
        end
    end

    // Flag any input digit outside 0..9; also derive the saturated result.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
        b_ext = BW'(w_shift[SHIFTS-1:0]);
        sat   = (b_ext > Y_MAX);
    end

    // Next-state and datapath updates; an invalid input spends one pending cycle
    // in SHIFT so DONE lands one cycle after the accepting edge.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = {a, {SHIFTS{1'b0}}};
                    cnt_d   = '0;
                    bad_d   = digit_bad;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bad_q) begin
                    bad_d   = 1'b0;
                    y_d     = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    w_d   = w_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SHIFTS - 1)) begin
                        y_d     = sat ? {OUT_W{1'b1}} : b_ext[OUT_W-1:0];
                        ovf_d   = sat;
                        err_d   = 1'b0;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign y    = y_q;
    assign ovf  = ovf_q;
    assign err  = err_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed vector bench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] a_in;
    logic [7:0]  y;
    logic        ovf;
    logic        err;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  y;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    bcd_to_bin #(.DIGITS(3), .OUT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .y     (y),
        .ovf   (ovf),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no summary expected summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after an accepting edge; counts edges until DONE is seen.
    task automatic wait_done(output int lat, output int busy_n, output bit got);
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic do_conv(input logic [11:0] av, output int lat, output int busy_n, output bit got);
        @(negedge clk);
        a_in  = av;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, busy_n, got);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int bn;
        bit got;
        int extra;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{12'h255, 8'd255, 1'b0, 1'b0, 10};
        vecs[1]  = '{12'h128, 8'd128, 1'b0, 1'b0, 10};
        vecs[2]  = '{12'h000, 8'd0,   1'b0, 1'b0, 10};
        vecs[3]  = '{12'h999, 8'hFF,  1'b1, 1'b0, 10};
        vecs[4]  = '{12'h256, 8'hFF,  1'b1, 1'b0, 10};
        vecs[5]  = '{12'h0A7, 8'd0,   1'b0, 1'b1, 1};
        vecs[6]  = '{12'h042, 8'd42,  1'b0, 1'b0, 10};
        vecs[7]  = '{12'h200, 8'd200, 1'b0, 1'b0, 10};
        vecs[8]  = '{12'h001, 8'd1,   1'b0, 1'b0, 10};
        vecs[9]  = '{12'h099, 8'd99,  1'b0, 1'b0, 10};
        vecs[10] = '{12'h10F, 8'd0,   1'b0, 1'b1, 1};
        vecs[11] = '{12'h100, 8'd100, 1'b0, 1'b0, 10};
        vecs[12] = '{12'hA00, 8'd0,   1'b0, 1'b1, 1};
        vecs[13] = '{12'h090, 8'd90,  1'b0, 1'b0, 10};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_y", y, 0);
        check("reset_ovf", ovf, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_conv(vecs[i].a, lat, bn, got);
            check($sformatf("v%0d_done_seen", i), got, 1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_y", i), y, vecs[i].y);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            check($sformatf("v%0d_err", i), err, vecs[i].err);
            check($sformatf("v%0d_busy_at_done", i), busy, 0);
            if (!vecs[i].err) begin
                check($sformatf("v%0d_busy_cycles", i), bn, 10);
                check($sformatf("v%0d_bcd_field_zero", i), dut.w_q[21:10], 0);
            end
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), done, 0);
            check($sformatf("v%0d_y_hold", i), y, vecs[i].y);
        end

        // START held high: 128 then 000 back to back; A changed mid-conversion.
        @(negedge clk);
        a_in  = 12'h128;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = 12'h000;
        @(posedge clk);
        wait_done(lat, bn, got);
        check("b2b_first_seen", got, 1);
        check("b2b_first_latency", lat, 9);
        check("b2b_first_y", y, 128);
        check("b2b_first_ovf", ovf, 0);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bn, got);
        check("b2b_second_seen", got, 1);
        check("b2b_second_latency", lat, 10);
        check("b2b_second_y", y, 0);
        check("b2b_second_ovf", ovf, 0);

        // START pulsed while busy converting 042 is ignored.
        @(negedge clk);
        a_in  = 12'h042;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_in  = 12'h050;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bn, got);
        check("ignore_seen", got, 1);
        check("ignore_latency", lat, 6);
        check("ignore_y", y, 42);
        count_done(20, extra);
        check("ignore_no_second_done", extra, 0);

        // Reset asserted after the fifth shift of 200 aborts with no DONE.
        @(negedge clk);
        a_in  = 12'h200;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_y", y, 0);
        check("abort_ovf", ovf, 0);
        check("abort_err", err, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(20, extra);
        check("abort_no_done", extra, 0);
        do_conv(12'h200, lat, bn, got);
        check("restart_seen", got, 1);
        check("restart_latency", lat, 10);
        check("restart_y", y, 200);
        check("restart_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
